// File: rtl/thermal_drive_ctrl.sv
// Trip controller: start/drive/refuel/done FSM with a debounced thermal shutdown
// that pauses driving without disturbing trip state.
module thermal_drive_ctrl #(
    parameter int OVH_CYCLES  = 4,
    parameter int COOL_CYCLES = 8
) (
    input  logic       clk,
    input  logic       aresetn,
    input  logic       cpu_overheated,
    input  logic       start,
    input  logic       arrived,
    input  logic       gas_tank_empty,
    input  logic       refuel_done,
    output logic       shut_off_computer,
    output logic       keep_driving,
    output logic       refuel_req,
    output logic       trip_done,
    output logic [3:0] refuel_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        REFUEL = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] OVH_LAST  = 8'(OVH_CYCLES - 1);
    localparam logic [7:0] COOL_LAST = 8'(COOL_CYCLES - 1);

    state_t     r_state;
    logic [7:0] r_heat_cnt;
    logic [7:0] r_cool_cnt;
    logic       r_shut;
    logic [3:0] r_refuel_cnt;

    state_t     w_next;
    logic       w_start_ok;

    // Thermal filter: each counter only runs in its own half of the hysteresis.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_heat_cnt <= 8'd0;
            r_cool_cnt <= 8'd0;
            r_shut     <= 1'b0;
        end else if (!r_shut) begin
            r_cool_cnt <= 8'd0;
            if (!cpu_overheated) begin
                r_heat_cnt <= 8'd0;
            end else if (r_heat_cnt == OVH_LAST) begin
                r_heat_cnt <= 8'd0;
                r_shut     <= 1'b1;
            end else begin
                r_heat_cnt <= r_heat_cnt + 8'd1;
            end
        end else begin
            r_heat_cnt <= 8'd0;
            if (cpu_overheated) begin
                r_cool_cnt <= 8'd0;
            end else if (r_cool_cnt == COOL_LAST) begin
                r_cool_cnt <= 8'd0;
                r_shut     <= 1'b0;
            end else begin
                r_cool_cnt <= r_cool_cnt + 8'd1;
            end
        end
    end

    assign w_start_ok = (r_state == IDLE || r_state == DONE) && start;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    if (arrived)             w_next = DONE;
                    else if (gas_tank_empty) w_next = REFUEL;
                    else                     w_next = DRIVE;
                end
            end
            DRIVE: begin
                if (arrived)             w_next = DONE;
                else if (gas_tank_empty) w_next = REFUEL;
            end
            REFUEL: begin
                if (arrived)                            w_next = DONE;
                else if (refuel_done && !gas_tank_empty) w_next = DRIVE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Count only entries into REFUEL; a start edge resets the tally first.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= IDLE;
            r_refuel_cnt <= 4'd0;
        end else begin
            r_state <= w_next;
            if (w_start_ok)
                r_refuel_cnt <= (w_next == REFUEL) ? 4'd1 : 4'd0;
            else if (w_next == REFUEL && r_state != REFUEL && r_refuel_cnt != 4'd15)
                r_refuel_cnt <= r_refuel_cnt + 4'd1;
        end
    end

    assign shut_off_computer = r_shut;
    assign keep_driving      = (r_state == DRIVE) && !r_shut;
    assign refuel_req        = (r_state == REFUEL);
    assign trip_done         = (r_state == DONE);
    assign refuel_count      = r_refuel_cnt;

endmodule

// File: tb/tb_thermal_drive_ctrl.sv
// Directed bench for thermal_drive_ctrl with hand-computed expectations.
module tb_thermal_drive_ctrl;

    logic       clk = 1'b0;
    logic       aresetn;
    logic       cpu_overheated, start, arrived, gas_tank_empty, refuel_done;
    logic       shut_off_computer, keep_driving, refuel_req, trip_done;
    logic [3:0] refuel_count;

    int n_chk  = 0;
    int n_fail = 0;

    thermal_drive_ctrl #(.OVH_CYCLES(4), .COOL_CYCLES(8)) dut (
        .clk               (clk),
        .aresetn           (aresetn),
        .cpu_overheated    (cpu_overheated),
        .start             (start),
        .arrived           (arrived),
        .gas_tank_empty    (gas_tank_empty),
        .refuel_done       (refuel_done),
        .shut_off_computer (shut_off_computer),
        .keep_driving      (keep_driving),
        .refuel_req        (refuel_req),
        .trip_done         (trip_done),
        .refuel_count      (refuel_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic sh, input logic kd,
                            input logic rr, input logic td, input logic [3:0] rc);
        chk({tag, ".shut"}, 8'(shut_off_computer), 8'(sh));
        chk({tag, ".keep"}, 8'(keep_driving), 8'(kd));
        chk({tag, ".rreq"}, 8'(refuel_req), 8'(rr));
        chk({tag, ".done"}, 8'(trip_done), 8'(td));
        chk({tag, ".rcnt"}, 8'(refuel_count), 8'(rc));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        aresetn = 1'b0; cpu_overheated = 1'b0; start = 1'b0;
        arrived = 1'b0; gas_tank_empty = 1'b0; refuel_done = 1'b0;

        // V1: reset, plain trip
        #12;
        chk_outs("rst", 0, 0, 0, 0, 0);
        #2 aresetn = 1'b1;
        tick();
        chk_outs("post_rst", 0, 0, 0, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_outs("v1_drive", 0, 1, 0, 0, 0);
        arrived = 1'b1;
        tick();
        arrived = 1'b0;
        chk_outs("v1_done", 0, 0, 0, 1, 0);

        // V2: refuel cycles and saturation
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_outs("v2_drive", 0, 1, 0, 0, 0);
        gas_tank_empty = 1'b1;
        tick();
        chk_outs("v2_refuel", 0, 0, 1, 0, 1);
        refuel_done = 1'b1;
        tick();
        chk_outs("v2_still_empty", 0, 0, 1, 0, 1);
        gas_tank_empty = 1'b0;
        tick();
        refuel_done = 1'b0;
        chk_outs("v2_back", 0, 1, 0, 0, 1);
        for (int i = 2; i <= 16; i++) begin
            gas_tank_empty = 1'b1;
            tick();
            chk("v2_loop_rcnt", 8'(refuel_count), (i > 15) ? 8'd15 : 8'(i));
            chk("v2_loop_rreq", 8'(refuel_req), 8'd1);
            gas_tank_empty = 1'b0;
            refuel_done = 1'b1;
            tick();
            refuel_done = 1'b0;
            chk("v2_loop_keep", 8'(keep_driving), 8'd1);
        end
        chk_outs("v2_sat", 0, 1, 0, 0, 15);

        // V3: hot 3, cool 1, hot 4 -> shutdown on the 8th edge
        cpu_overheated = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("v3_hot_a", 8'(shut_off_computer), 8'd0);
        end
        cpu_overheated = 1'b0;
        tick();
        chk("v3_gap", 8'(shut_off_computer), 8'd0);
        cpu_overheated = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("v3_hot_b", 8'(shut_off_computer), (i == 3) ? 8'd1 : 8'd0);
        end
        chk_outs("v3_paused", 1, 0, 0, 0, 15);

        // V4: cool 7, hot 1, cool 8 -> clears on the 16th edge
        cpu_overheated = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("v4_cool_a", 8'(shut_off_computer), 8'd1);
        end
        cpu_overheated = 1'b1;
        tick();
        chk("v4_blip", 8'(shut_off_computer), 8'd1);
        cpu_overheated = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("v4_cool_b", 8'(shut_off_computer), (i == 7) ? 8'd0 : 8'd1);
        end
        chk_outs("v4_resume", 0, 1, 0, 0, 15);

        // V5: arrived beats gas empty; restart clears count
        arrived = 1'b1;
        gas_tank_empty = 1'b1;
        tick();
        arrived = 1'b0;
        gas_tank_empty = 1'b0;
        chk_outs("v5_done", 0, 0, 0, 1, 15);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_outs("v5_restart", 0, 1, 0, 0, 0);

        // V6: reset during REFUEL with shutdown active
        gas_tank_empty = 1'b1;
        tick();
        chk_outs("v6_refuel", 0, 0, 1, 0, 1);
        cpu_overheated = 1'b1;
        repeat (4) tick();
        chk_outs("v6_hot", 1, 0, 1, 0, 1);
        #2 aresetn = 1'b0;
        #1;
        chk_outs("v6_async", 0, 0, 0, 0, 0);
        cpu_overheated = 1'b0;
        #3 aresetn = 1'b1;
        tick();
        chk_outs("v6_idle", 0, 0, 0, 0, 0);
        // start with gas empty enters REFUEL directly and counts it
        start = 1'b1;
        tick();
        start = 1'b0;
        gas_tank_empty = 1'b0;
        chk_outs("v6_start_refuel", 0, 0, 1, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
